// File: rtl/sram_arbiter_pkg.sv
// Shared types for the IF/MEM single-port SRAM arbiter: FSM states, owner encoding, counter width.
package sram_arbiter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state down counter for one SRAM access; load sets the cycle budget, dec counts it down.
// Latency: count updates one cycle after load/dec; zero is combinational from the count.
// Backpressure: none, it simply holds at zero.
module sram_wait_counter
  import sram_arbiter_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between IF and MEM, MEM with fixed priority; operands latched at grant.
// Latency: request seen in IDLE at cycle t -> ready pulse at t+WAIT_CYCLES+1; one access per WAIT_CYCLES+2.
// Backpressure: the waiting requester sees stall (req & ~ready) until its own one-cycle ready pulse.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int LEN         = 32,
  parameter int SRAM_ADDR_W = 17,
  parameter int WAIT_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   if_req,
  input  logic [LEN-1:0]         if_addr,
  output logic [LEN-1:0]         if_rdata,
  output logic                   if_ready,
  output logic                   if_stall,
  input  logic                   mem_rd_en,
  input  logic                   mem_wr_en,
  input  logic [LEN-1:0]         mem_addr,
  input  logic [LEN-1:0]         mem_wdata,
  output logic [LEN-1:0]         mem_rdata,
  output logic                   mem_ready,
  output logic                   mem_stall,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [LEN-1:0]         sram_wdata,
  input  logic [LEN-1:0]         sram_rdata,
  output logic                   sram_ce_n,
  output logic                   sram_we_n
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

  state_t                 state, state_nxt;
  owner_t                 owner_q;
  logic                   store_q;
  logic [SRAM_ADDR_W-1:0] addr_q;
  logic [LEN-1:0]         wdata_q;
  logic [LEN-1:0]         if_rdata_q, mem_rdata_q;

  logic mem_req;
  logic grant, grant_mem, cnt_dec, cnt_zero, capture;

  // Byte-offset bits and bits above the SRAM range are dropped, so addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], if_addr[LEN-1:SRAM_ADDR_W+2],
                              mem_addr[1:0], mem_addr[LEN-1:SRAM_ADDR_W+2]};

  assign mem_req = mem_rd_en | mem_wr_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_mem = 1'b0;
    cnt_dec   = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_req) begin
          grant     = 1'b1;
          grant_mem = 1'b1;
          state_nxt = ACCESS;
        end else if (if_req) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      // Always return to IDLE so a held request cannot be served twice back to back.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  sram_wait_counter u_wait_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (grant),
    .dec      (cnt_dec),
    .load_val (CNT_INIT),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_IF;
      store_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      owner_q <= grant_mem ? OWN_MEM : OWN_IF;
      store_q <= grant_mem & mem_wr_en;
      addr_q  <= grant_mem ? mem_addr[SRAM_ADDR_W+1:2] : if_addr[SRAM_ADDR_W+1:2];
      wdata_q <= mem_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else if (capture && !store_q) begin
      if (owner_q == OWN_MEM) mem_rdata_q <= sram_rdata;
      else                    if_rdata_q  <= sram_rdata;
    end
  end

  assign if_ready   = (state == DONE) && (owner_q == OWN_IF);
  assign mem_ready  = (state == DONE) && (owner_q == OWN_MEM);
  assign if_stall   = if_req & ~if_ready;
  assign mem_stall  = mem_req & ~mem_ready;
  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_ce_n  = (state != ACCESS);
  assign sram_we_n  = ~((state == ACCESS) && store_q);

endmodule
